// File: rtl/adc_stream_serializer.sv
// rtl/adc_stream_serializer.sv - parallel-to-serial word transmitter with frame marker and done pulse
//
// Accepts one WIDTH-bit word per din_valid/din_ready handshake and shifts it
// out on sout, holding each bit for DIV clocks. sframe marks the first bit of
// each word; done pulses for one cycle after the last bit period of a word.
//
// Ports:
//   clk        system clock, all logic on posedge
//   rst_n      asynchronous active-low reset
//   din        parallel word to transmit
//   din_valid  din holds a word to send
//   din_ready  block can accept a word this cycle (combinational)
//   sout       serial data bit, registered
//   sframe     high for all DIV cycles of the first bit of each word
//   busy       high while a word is being shifted
//   done       one-cycle pulse after the last bit of a word completes
module adc_stream_serializer #(
  parameter int WIDTH     = 4,
  parameter int DIV       = 1,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             sout,
  output logic             sframe,
  output logic             busy,
  output logic             done
);

  localparam int BW = $clog2(WIDTH);
  localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);
  localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);

  typedef enum logic {S_IDLE, S_SHIFT} state_t;

  state_t           r_state,   w_state_nxt;
  logic [WIDTH-1:0] r_shift,   w_shift_nxt;
  logic [BW-1:0]    r_bit_cnt, w_bit_cnt_nxt;
  logic [DW-1:0]    r_div_cnt, w_div_cnt_nxt;
  logic             r_sout,    w_sout_nxt;
  logic             r_sframe,  w_sframe_nxt;
  logic             r_busy,    w_busy_nxt;
  logic             r_done,    w_done_nxt;

  logic             w_bit_end;
  logic             w_word_end;
  logic             w_accept;
  logic             w_first_bit;
  logic             w_next_bit;
  logic [WIDTH-1:0] w_shifted;

  // The outgoing bit always sits at one end of r_shift; the register shifts
  // toward that end so the following bit is next in line.
  assign w_first_bit = MSB_FIRST ? din[WIDTH-1]     : din[0];
  assign w_next_bit  = MSB_FIRST ? r_shift[WIDTH-2] : r_shift[1];
  assign w_shifted   = MSB_FIRST ? {r_shift[WIDTH-2:0], 1'b0}
                                 : {1'b0, r_shift[WIDTH-1:1]};

  assign w_bit_end  = (r_div_cnt == DIV_LAST);
  assign w_word_end = (r_state == S_SHIFT) && w_bit_end && (r_bit_cnt == BIT_LAST);
  // Ready during the last clock of the last bit lets words run back to back.
  assign din_ready  = (r_state == S_IDLE) || w_word_end;
  assign w_accept   = din_valid && din_ready;

  always_comb begin
    w_state_nxt   = r_state;
    w_shift_nxt   = r_shift;
    w_bit_cnt_nxt = r_bit_cnt;
    w_div_cnt_nxt = r_div_cnt;
    w_sout_nxt    = r_sout;
    w_sframe_nxt  = r_sframe;
    w_done_nxt    = 1'b0;

    if (w_accept) begin
      w_state_nxt   = S_SHIFT;
      w_shift_nxt   = din;
      w_bit_cnt_nxt = '0;
      w_div_cnt_nxt = '0;
      w_sout_nxt    = w_first_bit;
      w_sframe_nxt  = 1'b1;
      // A reload on the final edge still reports completion of the old word.
      w_done_nxt    = w_word_end;
    end else if (r_state == S_SHIFT) begin
      if (!w_bit_end) begin
        w_div_cnt_nxt = r_div_cnt + DW'(1);
      end else if (r_bit_cnt == BIT_LAST) begin
        w_state_nxt   = S_IDLE;
        w_shift_nxt   = '0;
        w_bit_cnt_nxt = '0;
        w_div_cnt_nxt = '0;
        w_sout_nxt    = 1'b0;
        w_sframe_nxt  = 1'b0;
        w_done_nxt    = 1'b1;
      end else begin
        w_shift_nxt   = w_shifted;
        w_bit_cnt_nxt = r_bit_cnt + BW'(1);
        w_div_cnt_nxt = '0;
        w_sout_nxt    = w_next_bit;
        w_sframe_nxt  = 1'b0;
      end
    end

    w_busy_nxt = (w_state_nxt == S_SHIFT);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_shift   <= '0;
      r_bit_cnt <= '0;
      r_div_cnt <= '0;
      r_sout    <= 1'b0;
      r_sframe  <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_shift   <= w_shift_nxt;
      r_bit_cnt <= w_bit_cnt_nxt;
      r_div_cnt <= w_div_cnt_nxt;
      r_sout    <= w_sout_nxt;
      r_sframe  <= w_sframe_nxt;
      r_busy    <= w_busy_nxt;
      r_done    <= w_done_nxt;
    end
  end

  assign sout   = r_sout;
  assign sframe = r_sframe;
  assign busy   = r_busy;
  assign done   = r_done;

endmodule
